// File: rtl/sad_pkg.sv
// sad_pkg: FSM states, default sizes and the SAD init constant for sad_search_ctrl
package sad_pkg;
  localparam int SAD_DW = 8;
  localparam int SAD_SW = 32;
  localparam int SAD_BLK_LEN = 16;
  localparam int SAD_NCAND = 8;
  localparam logic [63:0] SAD_INIT = '1;
  typedef enum logic [2:0] {IDLE, START, FEED, WAIT, CMP, DONE} state_e;
endpackage

// File: rtl/sad_search_ctrl_if.sv
// sad_search_ctrl_if: sample-RAM and SAD-core bus; master = controller, slave = RAMs plus core
interface sad_search_ctrl_if
  import sad_pkg::*;
#(
  parameter int DW  = SAD_DW,
  parameter int SW  = SAD_SW,
  parameter int RAW = 4,
  parameter int CAW = 7
);
  logic [RAW-1:0] ref_addr;
  logic [CAW-1:0] cand_addr;
  logic [DW-1:0]  ref_data;
  logic [DW-1:0]  cand_data;
  logic           sad_enb;
  logic [DW-1:0]  sad_dta;
  logic [DW-1:0]  sad_dtb;
  logic [SW-1:0]  sad_dt;
  logic           sad_busy;
  modport master (output ref_addr, cand_addr, sad_enb, sad_dta, sad_dtb,
                  input  ref_data, cand_data, sad_dt, sad_busy);
  modport slave  (input  ref_addr, cand_addr, sad_enb, sad_dta, sad_dtb,
                  output ref_data, cand_data, sad_dt, sad_busy);
endinterface

// File: rtl/sad_min_track.sv
// sad_min_track: running minimum SAD and its index, strict-less update; threshold hit with SAD_SEARCH_THRESH_EN
module sad_min_track
  import sad_pkg::*;
#(
  parameter int SW = SAD_SW,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [SW-1:0] sad_i,
  input  logic [IW-1:0] idx_i,
`ifdef SAD_SEARCH_THRESH_EN
  input  logic [SW-1:0] thresh_i,
  output logic          hit_o,
`endif
  output logic [SW-1:0] best_sad_o,
  output logic [IW-1:0] best_idx_o
);
  logic [SW-1:0] best_sad_q;
  logic [IW-1:0] best_idx_q;
  logic          lt;
  assign lt = sad_i < best_sad_q;
  assign best_sad_o = best_sad_q;
  assign best_idx_o = best_idx_q;
`ifdef SAD_SEARCH_THRESH_EN
  logic [SW-1:0] thresh_q;
  assign hit_o = (lt ? sad_i : best_sad_q) <= thresh_q;
  // threshold is captured when a search is accepted
  always_ff @(posedge clk)
    thresh_q <= rst ? '0 : clr_i ? thresh_i : thresh_q;
`endif
  // clear on reset or new search; ties keep the earlier (lower) index
  always_ff @(posedge clk)
    if (rst || clr_i) begin
      best_sad_q <= SW'(SAD_INIT);
      best_idx_q <= '0;
    end else if (en_i && lt) begin
      best_sad_q <= sad_i;
      best_idx_q <= idx_i;
    end
endmodule

// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl: sequences the SAD core over NCAND candidates, reports min SAD and index; SAD_SEARCH_THRESH_EN adds early exit
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int DW      = SAD_DW,
  parameter int SW      = SAD_SW,
  parameter int BLK_LEN = SAD_BLK_LEN,
  parameter int NCAND   = SAD_NCAND,
  parameter int RAW     = $clog2(BLK_LEN),
  parameter int CAW     = $clog2(NCAND * BLK_LEN),
  parameter int IW      = NCAND > 1 ? $clog2(NCAND) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [IW-1:0] best_idx_o,
  output logic [SW-1:0] best_sad_o,
  sad_search_ctrl_if.master bus
`ifdef SAD_SEARCH_THRESH_EN
  ,
  input  logic [SW-1:0] thresh_i,
  output logic          early_o
`endif
);
  state_e         state_q;
  logic [IW-1:0]  cand_q;
  logic [RAW-1:0] ref_q;
  logic [CAW-1:0] caddr_q;
  logic           busy_q, done_q, enb_q;
  logic           clr, en, hit, last;
  assign clr = state_q == IDLE && start_i;
  assign en = state_q == CMP;
  assign last = cand_q == IW'(NCAND - 1);
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bus.ref_addr = ref_q;
  assign bus.cand_addr = caddr_q;
  assign bus.sad_enb = enb_q;
  assign bus.sad_dta = bus.ref_data;
  assign bus.sad_dtb = bus.cand_data;
`ifdef SAD_SEARCH_THRESH_EN
  logic early_q;
  assign early_o = early_q;
`else
  assign hit = 1'b0;
`endif
  sad_min_track #(.SW(SW), .IW(IW)) u_min (
    .clk(clk),
    .rst(rst),
    .clr_i(clr),
    .en_i(en),
    .sad_i(bus.sad_dt),
    .idx_i(cand_q),
`ifdef SAD_SEARCH_THRESH_EN
    .thresh_i(thresh_i),
    .hit_o(hit),
`endif
    .best_sad_o(best_sad_o),
    .best_idx_o(best_idx_o)
  );
  // search FSM; candidate blocks are contiguous so the candidate address just keeps counting
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cand_q <= '0;
      ref_q <= '0;
      caddr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      enb_q <= 1'b0;
`ifdef SAD_SEARCH_THRESH_EN
      early_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      enb_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= START;
          cand_q <= '0;
          ref_q <= '0;
          caddr_q <= '0;
          busy_q <= 1'b1;
          enb_q <= 1'b1;
`ifdef SAD_SEARCH_THRESH_EN
          early_q <= 1'b0;
`endif
        end
        START: begin
          state_q <= FEED;
          ref_q <= RAW'(1);
          caddr_q <= caddr_q + 1'b1;
        end
        FEED: if (ref_q == RAW'(BLK_LEN - 1)) state_q <= WAIT;
        else begin
          ref_q <= ref_q + 1'b1;
          caddr_q <= caddr_q + 1'b1;
        end
        WAIT: if (!bus.sad_busy) state_q <= CMP;
        CMP: if (last || hit) begin
          state_q <= DONE;
          done_q <= 1'b1;
          busy_q <= 1'b0;
`ifdef SAD_SEARCH_THRESH_EN
          early_q <= hit;
`endif
        end else begin
          state_q <= START;
          cand_q <= cand_q + 1'b1;
          ref_q <= '0;
          caddr_q <= caddr_q + 1'b1;
          enb_q <= 1'b1;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb_sad_search_ctrl: directed bench with RAM and SAD-core models; threshold scenario under SAD_SEARCH_THRESH_EN
module tb_sad_search_ctrl;
  localparam int BL = 16;
  localparam int NC = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;
  logic [2:0] bidx;
  logic [31:0] bsad;
  int pass_n = 0;
  int tot_n = 0;
`ifdef SAD_SEARCH_THRESH_EN
  logic [31:0] thresh = 32'd0;
  logic early;
`endif
  sad_search_ctrl_if #(.DW(8), .SW(32), .RAW(4), .CAW(7)) bus ();
  sad_search_ctrl #(.DW(8), .SW(32), .BLK_LEN(BL), .NCAND(NC)) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start),
    .busy_o(busy),
    .done_o(done),
    .best_idx_o(bidx),
    .best_sad_o(bsad),
    .bus(bus)
`ifdef SAD_SEARCH_THRESH_EN
    ,
    .thresh_i(thresh),
    .early_o(early)
`endif
  );
  always #5 clk = ~clk;
  logic [7:0] ref_mem [BL];
  logic [7:0] cand_mem [NC*BL];
  // sample RAMs, one-cycle read latency
  always @(posedge clk) begin
    bus.ref_data <= ref_mem[bus.ref_addr];
    bus.cand_data <= cand_mem[bus.cand_addr];
  end
  int stretch = 0;
  bit force1 = 1'b0;
  logic [31:0] acc = 32'd0;
  int cnt = 0;
  int ext = 0;
  bit cbusy = 1'b0;
  assign bus.sad_busy = cbusy;
  assign bus.sad_dt = force1 ? 32'hFFFF_FFFF : acc;
  // SAD core model: clear on enb, BLK_LEN adds with busy high, optional extra busy cycles
  always @(posedge clk)
    if (bus.sad_enb) begin
      acc <= 32'd0;
      cnt <= BL;
      ext <= stretch;
      cbusy <= 1'b1;
    end else if (cnt > 0) begin
      acc <= acc + 32'(bus.sad_dta > bus.sad_dtb ? bus.sad_dta - bus.sad_dtb : bus.sad_dtb - bus.sad_dta);
      cnt <= cnt - 1;
      if (cnt == 1 && ext == 0) cbusy <= 1'b0;
    end else if (ext > 0) begin
      ext <= ext - 1;
      if (ext == 1) cbusy <= 1'b0;
    end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input logic [7:0] rv, input logic [7:0] cv, input int ca, input logic [7:0] av,
                      input int cb, input logic [7:0] bv);
    for (int i = 0; i < BL; i++) ref_mem[i] = rv;
    for (int j = 0; j < NC*BL; j++) cand_mem[j] = (j / BL == ca) ? av : (j / BL == cb) ? bv : cv;
  endtask
  task automatic search(input string tag, input bit hold, input int exp_lat, input int exp_enb,
                        input logic [2:0] xidx, input logic [31:0] xsad, input bit xearly);
    int n;
    int enbs;
    start = 1'b1;
    step;
    if (!hold) start = 1'b0;
    n = 1;
    enbs = bus.sad_enb ? 1 : 0;
    while (!done && n < 2000) begin
      if (hold) start = (n != 50);
      step;
      n++;
      if (bus.sad_enb) enbs++;
    end
    chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    chk({tag, " enb pulses"}, 64'(enbs), 64'(exp_enb));
    chk({tag, " best_idx"}, 64'(bidx), 64'(xidx));
    chk({tag, " best_sad"}, 64'(bsad), 64'(xsad));
    chk({tag, " busy at done"}, 64'(busy), 64'd0);
`ifdef SAD_SEARCH_THRESH_EN
    chk({tag, " early"}, 64'(early), 64'(xearly));
`else
    if (xearly) begin end
`endif
    step;
    chk({tag, " done one cycle"}, 64'(done), 64'd0);
    chk({tag, " idle after done"}, 64'(busy), 64'd0);
    if (hold) begin
      step;
      chk({tag, " restart after idle"}, 64'(busy), 64'd1);
      start = 1'b0;
    end else begin
      repeat (3) step;
      chk({tag, " stays idle"}, 64'(busy), 64'd0);
      chk({tag, " sad held"}, 64'(bsad), 64'(xsad));
    end
  endtask
  initial begin
    int dn;
    fill(8'd24, 8'd32, 5, 8'd30, 5, 8'd30);
    repeat (2) step;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset idx", 64'(bidx), 64'd0);
    chk("reset sad", 64'(bsad), 64'hFFFF_FFFF);
    chk("reset enb", 64'(bus.sad_enb), 64'd0);
    chk("reset ref_addr", 64'(bus.ref_addr), 64'd0);
    chk("reset cand_addr", 64'(bus.cand_addr), 64'd0);
    rst = 1'b0;
    step;
    search("s1", 1'b0, 153, 8, 3'd5, 32'd96, 1'b0);
    fill(8'd24, 8'd32, 2, 8'd26, 6, 8'd26);
    search("s2 tie", 1'b0, 153, 8, 3'd2, 32'd32, 1'b0);
    search("s3 hold", 1'b1, 153, 8, 3'd2, 32'd32, 1'b0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    step;
    fill(8'd24, 8'd32, 5, 8'd30, 5, 8'd30);
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (61) step;
    chk("s4 busy before rst", 64'(busy), 64'd1);
    chk("s4 sad before rst", 64'(bsad), 64'd128);
    rst = 1'b1;
    step;
    chk("s4 rst busy", 64'(busy), 64'd0);
    chk("s4 rst enb", 64'(bus.sad_enb), 64'd0);
    chk("s4 rst sad", 64'(bsad), 64'hFFFF_FFFF);
    chk("s4 rst idx", 64'(bidx), 64'd0);
    rst = 1'b0;
    dn = 0;
    repeat (20) begin
      step;
      if (done) dn++;
    end
    chk("s4 no done after rst", 64'(dn), 64'd0);
    search("s4 rerun", 1'b0, 153, 8, 3'd5, 32'd96, 1'b0);
    stretch = 5;
    search("s5 stretch", 1'b0, 193, 8, 3'd5, 32'd96, 1'b0);
    stretch = 0;
    for (int i = 0; i < BL; i++) ref_mem[i] = 8'(i * 5);
    for (int j = 0; j < NC*BL; j++)
      cand_mem[j] = (j / BL == 7) ? 8'((j % BL) * 5) : (j / BL == 1) ? 8'((j % BL) * 5 + 1) : 8'd200;
    search("s6 ramp", 1'b0, 153, 8, 3'd7, 32'd0, 1'b1);
    force1 = 1'b1;
    search("s7 all ones", 1'b0, 153, 8, 3'd0, 32'hFFFF_FFFF, 1'b0);
    force1 = 1'b0;
`ifdef SAD_SEARCH_THRESH_EN
    fill(8'd24, 8'd32, 5, 8'd30, 5, 8'd30);
    thresh = 32'd100;
    search("s8 thresh", 1'b0, 115, 6, 3'd5, 32'd96, 1'b1);
    thresh = 32'd0;
`endif
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
